// File: rtl/unified_mem_arbiter.sv
//==============================================================================
//  Module      : unified_mem_arbiter
//  Description : Arbitrates one single-ported, variable-latency unified memory
//                between instruction fetch (I) and load/store (D). Data wins
//                by default; fetch is forced after STARVE_MAX consecutive data
//                grants taken while it was waiting. One transaction in flight,
//                with a per-transaction timeout that completes with err.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  // completion status
  output logic          err,
  // memory port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_valid
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0] CNT_LIM    = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] starve;   // consecutive D grants taken while fetch waited
  logic [CW-1:0] cnt;      // BUSY cycles already elapsed without m_valid

  // Arbitration, memory command sequencing and registered completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      starve  <= '0;
      cnt     <= '0;
      i_rdata <= '0;
      i_ready <= 1'b0;
      d_rdata <= '0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      m_en    <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req && ((starve < STARVE_LIM) || !i_req)) begin
            state   <= BUSY_D;
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            cnt     <= '0;
            // only grants that actually made fetch wait count toward starvation
            if (!i_req) begin
              starve <= '0;
            end else if (starve != STARVE_LIM) begin
              starve <= starve + 1'b1;
            end
          end else if (i_req) begin
            state   <= BUSY_I;
            m_en    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            cnt     <= '0;
            starve  <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          // a response arriving on the timeout cycle still counts as success
          if (m_valid || (cnt == CNT_LIM)) begin
            state   <= (state == BUSY_I) ? DONE_I : DONE_D;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            err     <= !m_valid;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              if (m_valid) begin
                i_rdata <= m_rdata;
              end
            end else begin
              d_ready <= 1'b1;
              // stores leave the previous load data visible
              if (m_valid && !m_we) begin
                d_rdata <= m_rdata;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // the ready pulse cycle never arbitrates, so requesters can update req
        DONE_I, DONE_D: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
//==============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Randomized scoreboard bench for unified_mem_arbiter. Two
//                requester processes issue fetches and loads/stores; a memory
//                responder answers with random latency (including the timeout
//                boundary, late and missing responses). Expected grants,
//                completion cycles, data and err are derived from the
//                arbitration rules and queued; a monitor pops and compares.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SM     = 4;
  localparam int TO     = 64;
  localparam int N_I    = 40;
  localparam int N_D    = 80;
  localparam int BUDGET = 1500;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready, err;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_valid;

  unified_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] rdata;
    bit          err;
    int          rcyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          starve_m = 0;
  logic [31:0] exp_i_rd = '0;
  logic [31:0] exp_d_rd = '0;
  bit          p_i = 0, p_d = 0, p_dwe = 0;
  logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwd = '0;
  bit          sb_on = 0;
  bit          inflight = 0;
  bit          force_mv = 0;
  logic [31:0] force_rd = '0;
  int          mv_cnt = -1;
  logic [31:0] mv_data = '0;
  bit          win_d, win_i;
  int          lat;
  bit          go = 0, i_fin = 0, d_fin = 0;

  // latency in cycles after the m_en cycle; -1 = never answer
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 13)  return $urandom_range(0, 3);
    if (r < 15)  return TO;
    if (r == 15) return TO - 1;
    if (r == 16) return TO + 1;
    if (r == 17) return TO + 2;
    return -1;
  endfunction

  // ---------------- monitor + memory responder ----------------
  always @(negedge clk) begin
    cyc++;

    if (i_ready || d_ready) begin
      inflight = 0;
      if (!sb_on || q.size() == 0) begin
        chk("unexpected_ready", {62'b0, i_ready, d_ready}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("ready_kind", {62'b0, i_ready, d_ready}, e.is_d ? 64'd1 : 64'd2);
        chk("ready_cycle", cyc, e.rcyc);
        chk("err", err, e.err);
        if (!e.err) begin
          if (!e.is_d) exp_i_rd = e.rdata;
          else if (!e.we) exp_d_rd = e.rdata;
        end
        chk("i_rdata", i_rdata, exp_i_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
        chk("done_m_addr", m_addr, 64'd0);
        chk("done_m_we_wdata", {m_we, m_wdata}, 64'd0);
      end
    end else if (err) begin
      chk("err_without_ready", err, 64'd0);
    end

    if (m_en && sb_on) begin
      win_d = p_d && ((starve_m < SM) || !p_i);
      win_i = !win_d && p_i;
      if (!win_d && !win_i) begin
        chk("spurious_m_en", m_en, 64'd0);
      end else begin
        chk("m_addr", m_addr, win_d ? p_daddr : p_iaddr);
        chk("m_we", m_we, win_d ? p_dwe : 1'b0);
        chk("m_wdata", m_wdata, win_d ? p_dwd : 32'd0);
        if (win_d) starve_m = p_i ? ((starve_m < SM) ? starve_m + 1 : SM) : 0;
        else       starve_m = 0;
        lat      = pick_lat();
        mv_data  = $urandom;
        e.is_d   = win_d;
        e.we     = win_d && p_dwe;
        e.rdata  = mv_data;
        e.err    = !(lat >= 0 && lat <= TO);
        e.rcyc   = cyc + (e.err ? TO : lat) + 1;
        q.push_back(e);
        mv_cnt   = lat;
        inflight = 1;
      end
    end

    if (sb_on) begin
      if (mv_cnt == 0) begin
        m_valid = 1'b1;
        m_rdata = mv_data;
      end else begin
        // stray responses while nothing is in flight must be ignored
        m_valid = !inflight && ($urandom_range(0, 7) == 0);
        m_rdata = $urandom;
      end
      if (mv_cnt >= 0) mv_cnt--;
    end else begin
      m_valid = force_mv;
      m_rdata = force_rd;
    end

    p_i     = i_req;
    p_d     = d_req;
    p_dwe   = d_we;
    p_iaddr = i_addr;
    p_daddr = d_addr;
    p_dwd   = d_wdata;
  end

  // ---------------- fetch requester ----------------
  initial begin
    int g, t;
    i_req = 0; i_addr = '0;
    wait (go);
    @(posedge clk); #1;
    for (int n = 0; n < N_I; n++) begin
      g = $urandom_range(0, 3);
      if (g != 0) begin
        i_req = 0;
        repeat (g) begin @(posedge clk); #1; end
      end
      i_req  = 1;
      i_addr = $urandom & 32'hFFFF_FFFC;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!i_ready && t < BUDGET);
      chk("i_handshake", i_ready, 64'd1);
    end
    i_req = 0;
    i_fin = 1;
  end

  // ---------------- data requester ----------------
  initial begin
    int g, t;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    wait (go);
    @(posedge clk); #1;
    for (int n = 0; n < N_D; n++) begin
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (g != 0) begin
        d_req = 0;
        repeat (g) begin @(posedge clk); #1; end
      end
      d_req   = 1;
      d_we    = $urandom_range(0, 1);
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!d_ready && t < BUDGET);
      chk("d_handshake", d_ready, 64'd1);
    end
    d_req = 0;
    d_fin = 1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_i_ready", i_ready, 64'd0);
    chk("rst_d_ready", d_ready, 64'd0);
    chk("rst_err", err, 64'd0);
    chk("rst_m_en", m_en, 64'd0);
    chk("rst_m_we_wdata", {m_we, m_wdata}, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);

    @(posedge clk); #1;
    sb_on = 1;
    reset = 1'b1;
    go    = 1;

    t = 0;
    while (!(i_fin && d_fin) && t < 40000) begin @(posedge clk); t++; end
    chk("random_phase_done", {62'b0, i_fin, d_fin}, 64'd3);
    repeat (6) @(posedge clk);
    chk("queue_drained", q.size(), 64'd0);

    // reset in the middle of a data load: the transaction must vanish
    @(posedge clk); #1;
    sb_on    = 0;
    force_mv = 0;
    d_req    = 1; d_we = 0; d_addr = 32'h80; d_wdata = '0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!m_en && t < 20);
    chk("rst_test_m_en", m_en, 64'd1);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    d_req = 0;
    #1;
    chk("async_rst_m_addr", m_addr, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    force_mv = 1;
    force_rd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    force_mv = 0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("post_rst_d_ready", {d_ready, i_ready, err}, 64'd0);
      chk("post_rst_m_bus", {m_en, m_we, m_wdata}, 64'd0);
      chk("post_rst_m_addr", m_addr, 64'd0);
      chk("post_rst_rdata", {i_rdata, d_rdata}, {exp_i_rd & 32'h0, exp_d_rd & 32'h0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
